// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, the word width and the address-legality check.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // A word address at or beyond depth is the same as any nonzero bit above the index field,
    // because depth is a power of two.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] word_idx;
        word_idx = addr >> 2;
        return (addr[1:0] != 2'b00) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_W storage: one synchronous write port, one combinational read port.
// It has no reset; the responder clears it word by word after every reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the pipeline data port: one load/store at a time,
// LATENCY wait states before the response, storage cleared after each reset.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] WAIT_LOAD = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    // Handshakes: a request transfers at an edge where req_valid && req_ready;
    // a response transfers at an edge where rsp_valid && rsp_ready. Both sides are
    // free to change their payload once the transfer edge has passed.

    state_t state, state_nx;
    logic [AW-1:0] clr_cnt, clr_cnt_nx;
    logic [2:0]    wait_cnt, wait_cnt_nx;

    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          accept;
    logic          commit;
    logic          cmt_write;
    logic [31:0]   cmt_addr;
    logic [31:0]   cmt_wdata;
    logic [AW-1:0] cmt_idx;
    logic          cmt_err;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    assign accept = (state == IDLE) && req_valid;

    always_comb begin
        state_nx    = state;
        clr_cnt_nx  = clr_cnt;
        wait_cnt_nx = wait_cnt;
        commit      = 1'b0;
        case (state)
            INIT: begin
                clr_cnt_nx = clr_cnt + 1'b1;
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        commit   = 1'b1;
                        state_nx = RESP;
                    end else begin
                        wait_cnt_nx = WAIT_LOAD;
                        state_nx    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    commit   = 1'b1;
                    state_nx = RESP;
                end else begin
                    wait_cnt_nx = wait_cnt - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = INIT;
        endcase
    end

    // With zero wait states the commit happens on the acceptance edge, so it
    // must use the live request rather than the captured copy.
    always_comb begin
        cmt_write = wr_q;
        cmt_addr  = addr_q;
        cmt_wdata = wdata_q;
        if (state == IDLE) begin
            cmt_write = req_write;
            cmt_addr  = req_addr;
            cmt_wdata = req_wdata;
        end
        cmt_idx = cmt_addr[AW+1:2];
        cmt_err = addr_err(cmt_addr, DEPTH);
    end

    // Reset suppresses any write so an aborted store never lands.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cmt_idx;
        mem_wdata = cmt_wdata;
        if (state == INIT) begin
            mem_we    = rst;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
        end else if (commit && cmt_write && !cmt_err) begin
            mem_we = rst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= INIT;
            clr_cnt  <= '0;
            wait_cnt <= 3'd0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            clr_cnt  <= clr_cnt_nx;
            wait_cnt <= wait_cnt_nx;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                rdata_q <= (cmt_write || cmt_err) ? '0 : mem_rdata;
                err_q   <= cmt_err;
            end else if ((state == RESP) && rsp_ready) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (cmt_idx),
        .rdata (mem_rdata)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port. It sits on the far end of the CPU's ALUResult/WriteData/MemWrite/ReadData interface.
- Accepts one word load/store request at a time over a valid/ready handshake and returns a response after a configurable number of wait states.
- Clears its storage after reset and flags misaligned or out-of-range accesses.
- Used in place of an ideal single-cycle memory to exercise pipeline stall logic.

Parameters:
- DEPTH, 64, number of 32-bit words stored (power of two, 2..1024).
- LATENCY, 1, wait-state cycles between acceptance and response (0..7).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store (sw), 0 = load (lw).
- req_addr  in  32  byte address (the CPU's ALUResult).
- req_wdata  in  32  store data (the CPU's WriteData).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response this cycle.
- rsp_rdata  out  32  load data (the CPU's ReadData); 0 for stores and errors.
- rsp_err  out  1  access was misaligned or out of range.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States are INIT, IDLE, WAIT and RESP.
- Reset (rst=0 at an edge):
  - state becomes INIT and the clear counter becomes 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1.
  - Reset in any state aborts the transaction in flight; no pending write commits and no response is issued.
- INIT:
  - Writes 0 to word[clear counter] each cycle and increments the counter.
  - After writing word DEPTH-1, moves to IDLE. INIT lasts exactly DEPTH cycles.
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1 and no other state asserts req_ready.
  - A request is accepted at the edge where req_valid=1 and req_ready=1.
  - On acceptance, req_write, req_addr and req_wdata are registered.
  - If LATENCY=0, next state is RESP. Otherwise next state is WAIT with the wait counter loaded with LATENCY-1.
- WAIT:
  - The wait counter decrements each cycle.
  - When the counter is 0, the transaction commits and the next state is RESP.
- Commit (on the edge entering RESP):
  - Word index = addr[log2(DEPTH)+1:2].
  - err = (addr[1:0] != 0) or (addr[31:log2(DEPTH)+2] != 0).
  - Store without err: word[index] is written with wdata; rsp_rdata=0.
  - Load without err: rsp_rdata = word[index] as it was before this edge.
  - With err: no write occurs, rsp_rdata=0, rsp_err=1.
- Timing:
  - For a request accepted at edge k, rsp_valid is first high in the cycle after edge k+LATENCY.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err stay stable until the handshake.
  - At the edge where rsp_ready=1: next state is IDLE, and rsp_valid, rsp_rdata and rsp_err clear to 0.
  - If rsp_ready=1 arrives on the first RESP cycle, the response lasts exactly one cycle.
- Input handling:
  - req_valid asserted in any state other than IDLE is ignored; it is not queued.
  - req_* inputs may change freely after acceptance.
- A store followed by a load to the same address returns the stored data, because the store commits before its response.
- The wait counter is 3 bits wide and never underflows.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (INIT, IDLE, WAIT, RESP);
  - the word width constant WORD_W=32;
  - the function addr_err(addr, depth).
- One sub-module, dmem_array: a DEPTH x 32 synchronous-write, combinational-read storage array with a single write port and a single read port. The responder FSM drives both ports, including the INIT clear.

Test Plan:
- Reset/init: hold rst=0 for 3 cycles, then release with DEPTH=64.
  -> req_ready=0 for exactly 64 cycles, then 1.
  -> A load from 0x0000_00FC returns 0, rsp_err=0.
- Store then load, LATENCY=1: store 0xDEAD_BEEF to 0x10, accepted at edge k.
  -> rsp_valid high after edge k+1, rsp_rdata=0.
  -> A following load from 0x10 returns 0xDEAD_BEEF.
- Latency sweep, LATENCY=0 and LATENCY=7: load accepted at edge k.
  -> rsp_valid first high after edge k (L=0) or after edge k+7 (L=7).
  -> req_ready=0 until the response handshake completes.
- Errors:
  - store 0x1234_5678 to 0x12 (misaligned) -> rsp_err=1;
  - store to 0x100 with DEPTH=64 (out of range) -> rsp_err=1;
  - then load 0x10 -> still returns the prior value; no word was corrupted.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load returning 0xCAFE_0001.
  -> rsp_valid and rsp_rdata stay stable for all 5 cycles.
  -> req_valid pulses during this time are ignored.
  -> IDLE is reached one cycle after rsp_ready=1.
- Reset mid-operation: assert rst=0 while in WAIT on a store of 0xAAAA_5555 to 0x20.
  -> No response is issued and INIT reruns.
  -> A later load of 0x20 returns 0.
